// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider.
// Divisor sets for simulation and for real 50 MHz hardware.
package clk_div_pkg;

  localparam int DEF_CNT_W = 32;
  localparam int MIN_DIV   = 2;

  localparam logic [4*32-1:0] DIV_SIM = {
    32'd16, 32'd8, 32'd4, 32'd2
  };

  localparam logic [4*32-1:0] DIV_HW = {
    32'd50000000, 32'd5000000,
    32'd500000, 32'd50000
  };

endpackage

// File: rtl/div_channel.sv
// One divider channel: phase counter, shadow/active divisor,
// square-wave output and rising-edge tick.
module div_channel #(
  parameter int CNT_W = 32,
  parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(2)
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active_div;
  logic [CNT_W-1:0] shadow_div;
  logic [CNT_W-1:0] shadow_nxt;
  logic [CNT_W-1:0] n_m1;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt_p1;
  logic             run;
  logic             bound;
  logic             hold;

  assign shadow_nxt = ld ? ld_val : shadow_div;
  assign n_m1       = active_div - CNT_W'(1);
  assign half       = active_div >> 1;
  assign cnt_p1     = cnt + CNT_W'(1);
  assign bound      = (cnt == n_m1);
  assign hold       = clr | ~en;

  // run stays low until the first boundary so no high phase
  // is emitted before the first full period has elapsed
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      active_div <= RST_DIV;
      shadow_div <= RST_DIV;
      run        <= 1'b0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
    end else begin
      shadow_div <= shadow_nxt;
      if (hold || bound) active_div <= shadow_nxt;
      if (hold) begin
        cnt     <= '0;
        run     <= 1'b0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (bound) begin
        cnt     <= '0;
        run     <= 1'b1;
        clk_out <= 1'b1;
        tick    <= 1'b1;
      end else begin
        cnt     <= cnt_p1;
        clk_out <= run & (cnt_p1 < half);
        tick    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_clock_divider.sv
// N-channel programmable divider off clk_50mhz with
// glitch-free retune, per-channel enable and common phase clear.
module multi_clock_divider
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEF_CNT_W,
  parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_DIV = DIV_SIM,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_50mhz,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic              wr_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic ch_ok;
  logic div_ok;
  logic wr_ok;

  // a full power-of-two channel count makes every index legal
  generate
    if (NUM_CH == (1 << CH_W)) begin : g_full
      assign ch_ok = 1'b1;
    end else begin : g_part
      assign ch_ok = (wr_ch < CH_W'(NUM_CH));
    end
  endgenerate

  assign div_ok = (wr_div >= CNT_W'(MIN_DIV));
  assign wr_ok  = wr_en & ch_ok & div_ok;

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en & ~wr_ok;
    end
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic ld;

      assign ld = wr_ok & (wr_ch == CH_W'(i));

      div_channel #(
        .CNT_W   (CNT_W),
        .RST_DIV (DEFAULT_DIV[i*CNT_W +: CNT_W])
      ) u_ch (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .en        (ch_en[i]),
        .clr       (sync_clr),
        .ld        (ld),
        .ld_val    (wr_div),
        .clk_out   (clk_out[i]),
        .tick      (tick[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_clock_divider.sv
// Randomised self-checking bench for multi_clock_divider against
// a countdown-to-next-rise model of each channel.
module tb_multi_clock_divider;

  localparam int NCH = 4;

  logic        clk_50mhz = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ch_en = '0;
  logic        sync_clr = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [31:0] wr_div = '0;
  logic        wr_err;
  logic [3:0]  clk_out;
  logic [3:0]  tick;

  logic        wr_en2 = 1'b0;
  logic [1:0]  wr_ch2 = '0;
  logic [31:0] wr_div2 = '0;
  logic        wr_err2;
  logic [2:0]  clk_out2;
  logic [2:0]  tick2;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk_50mhz = ~clk_50mhz;

  multi_clock_divider dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .ch_en     (ch_en),
    .sync_clr  (sync_clr),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_div    (wr_div),
    .wr_err    (wr_err),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  multi_clock_divider #(
    .NUM_CH      (3),
    .DEFAULT_DIV ({32'd8, 32'd4, 32'd2})
  ) dut3 (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .ch_en     (3'b000),
    .sync_clr  (1'b0),
    .wr_en     (wr_en2),
    .wr_ch     (wr_ch2),
    .wr_div    (wr_div2),
    .wr_err    (wr_err2),
    .clk_out   (clk_out2),
    .tick      (tick2)
  );

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, got, exp, $time);
  endtask

  // model: divisor pending, divisor of current period,
  // edges left until next rise, edges since last rise (-1 = none)
  int  pend[NCH];
  int  ndiv[NCH];
  int  to_rise[NCH];
  int  since[NCH];
  bit  m_err;
  int  defs[NCH] = '{2, 4, 8, 16};

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      pend[i]    = defs[i];
      ndiv[i]    = defs[i];
      to_rise[i] = defs[i];
      since[i]   = -1;
    end
    m_err = 1'b0;
  endtask

  task automatic m_step();
    bit legal;
    legal = wr_en && (wr_div >= 32'd2);
    m_err = wr_en && !legal;
    for (int i = 0; i < NCH; i++) begin
      if (legal && int'(wr_ch) == i) pend[i] = int'(wr_div);
      if (sync_clr || !ch_en[i]) begin
        ndiv[i]    = pend[i];
        to_rise[i] = pend[i];
        since[i]   = -1;
      end else begin
        to_rise[i]--;
        if (to_rise[i] == 0) begin
          ndiv[i]    = pend[i];
          to_rise[i] = pend[i];
          since[i]   = 0;
        end else if (since[i] >= 0) begin
          since[i]++;
        end
      end
    end
  endtask

  function automatic logic [8:0] model_vec();
    logic [8:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) begin
      v[i]     = (since[i] >= 0) && (since[i] < ndiv[i] / 2);
      v[4 + i] = (since[i] == 0);
    end
    v[8] = m_err;
    return v;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk_50mhz or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk_50mhz);
      if (!rst)
        check("cycle", 32'({wr_err, tick, clk_out}),
              32'(model_vec()));
    end
  end

  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin
      @(negedge clk_50mhz);
      n++;
    end while (!tick[ch] && n < 64);
    check("tick_seen", 32'(tick[ch]), 32'd1);
  endtask

  task automatic do_write(input int ch, input int div);
    wr_en  = 1'b1;
    wr_ch  = 2'(ch);
    wr_div = 32'(div);
    @(negedge clk_50mhz);
    wr_en  = 1'b0;
  endtask

  int n;
  int hi;

  initial begin
    @(negedge clk_50mhz);
    check("reset_state", 32'({wr_err, tick, clk_out}), 32'd0);

    // defaults: first rise of ch3 after 16 enabled cycles
    rst   = 1'b0;
    ch_en = 4'hF;
    wait_tick(3, n);
    check("ch3_first_rise", 32'(n), 32'd16);

    // retune ch1 mid-period to 6
    do_write(1, 6);
    wait_tick(1, n);
    check("ch1_old_period_end", 32'(n), 32'd3);
    wait_tick(1, n);
    check("ch1_period6", 32'(n), 32'd6);
    hi = int'(clk_out[1]);
    repeat (5) begin
      @(negedge clk_50mhz);
      hi += int'(clk_out[1]);
    end
    check("ch1_high6", 32'(hi), 32'd3);

    // odd divisor on ch2
    do_write(2, 5);
    wait_tick(2, n);
    wait_tick(2, n);
    check("ch2_period5", 32'(n), 32'd5);
    hi = int'(clk_out[2]);
    repeat (4) begin
      @(negedge clk_50mhz);
      hi += int'(clk_out[2]);
    end
    check("ch2_high5", 32'(hi), 32'd2);

    // rejected writes
    do_write(2, 1);
    check("err_div1", 32'(wr_err), 32'd1);
    do_write(2, 0);
    check("err_div0", 32'(wr_err), 32'd1);
    do_write(0, 3);
    check("err_ok", 32'(wr_err), 32'd0);
    wr_en2 = 1'b1; wr_ch2 = 2'd3; wr_div2 = 32'd5;
    @(negedge clk_50mhz);
    wr_en2 = 1'b0;
    check("err_bad_ch", 32'(wr_err2), 32'd1);
    wr_en2 = 1'b1; wr_ch2 = 2'd2;
    @(negedge clk_50mhz);
    wr_en2 = 1'b0;
    check("err_good_ch", 32'(wr_err2), 32'd0);
    check("dut3_idle", 32'({tick2, clk_out2}), 32'd0);
    wait_tick(2, n);
    wait_tick(2, n);
    check("ch2_unchanged", 32'(n), 32'd5);

    // drop ch3 enable during high phase
    for (int k = 0; k < 40 && !(clk_out[3] && !tick[3]); k++)
      @(negedge clk_50mhz);
    check("ch3_high_found", 32'(clk_out[3] & ~tick[3]), 32'd1);
    ch_en[3] = 1'b0;
    @(negedge clk_50mhz);
    check("ch3_drop", 32'(clk_out[3]), 32'd0);
    repeat (3) @(negedge clk_50mhz);
    ch_en[3] = 1'b1;
    wait_tick(3, n);
    check("ch3_reenable", 32'(n), 32'd16);

    // sync_clr at a random point
    repeat ($urandom_range(1, 20)) @(negedge clk_50mhz);
    sync_clr = 1'b1;
    @(negedge clk_50mhz);
    sync_clr = 1'b0;
    wait_tick(0, n);
    check("clr_ch0_rise", 32'(n), 32'd3);

    // random traffic checked by the model
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_50mhz);
      if ($urandom_range(0, 11) == 0)
        ch_en[$urandom_range(0, 3)] ^= 1'b1;
      sync_clr = ($urandom_range(0, 39) == 0);
      wr_en    = ($urandom_range(0, 7) == 0);
      wr_ch    = 2'($urandom_range(0, 3));
      wr_div   = 32'($urandom_range(0, 12));
    end
    @(negedge clk_50mhz);
    sync_clr = 1'b0;
    wr_en    = 1'b0;
    ch_en    = 4'hF;

    // async reset between edges while ch0 is high
    wait_tick(0, n);
    #1 rst = 1'b1;
    #1 check("async_rst", 32'({wr_err, tick, clk_out}), 32'd0);
    @(negedge clk_50mhz);
    rst = 1'b0;
    wait_tick(1, n);
    check("default_restored", 32'(n), 32'd4);

    repeat (4) @(negedge clk_50mhz);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
